// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame bit indices.
// The transmitter uses the same bit index constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int START_BIT = 0;
    localparam int STOP_BIT  = 9;
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser for an asynchronous level input.
// Resets to 1 so an idle-high line shows no spurious falling edge.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: state registers always use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises uart_rxd, samples each bit at its midpoint,
// and reports each frame with a one-cycle done or framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic       uart_rx_done,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_err,
    output logic       uart_rx_busy
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF_BIT     = BAUD_CNT_MAX / 2;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] BAUD_HALF = 16'(HALF_BIT);

    logic        rxd_sync;
    logic        rxd_prev_q;
    logic        start_edge;
    logic        baud_wrap;
    logic        at_half;

    uart_state_e state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    uart_sync #(.STAGES(2)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (uart_rxd),
        .sync_o  (rxd_sync)
    );

    assign start_edge = !rxd_sync && rxd_prev_q;
    assign baud_wrap  = (baud_cnt_q == BAUD_LAST);
    assign at_half    = (baud_cnt_q == BAUD_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_edge) state_d = START;
            START:   if (at_half) state_d = rxd_sync ? IDLE : DATA;
            DATA:    if (baud_wrap && bit_cnt_q == 4'(DATA_BITS)) state_d = STOP;
            STOP:    if (at_half) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters clear on the way into IDLE so a start edge right after mid-stop begins from zero.
    always_comb begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        if (state_q == IDLE || state_d == IDLE) begin
            baud_cnt_d = '0;
            bit_cnt_d  = 4'(START_BIT);
        end else if (baud_wrap) begin
            baud_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 4'd1;
        end
        if (state_q == DATA && at_half) begin
            shift_d[3'(bit_cnt_q - 4'd1)] = rxd_sync;
        end
    end

    always_comb begin
        uart_rx_busy = (state_q != IDLE);
        done_d       = (state_q == STOP) && at_half && rxd_sync;
        err_d        = (state_q == STOP) && at_half && !rxd_sync;
        data_d       = done_d ? shift_q : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_prev_q <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rxd_prev_q <= rxd_sync;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign uart_rx_done = done_q;
    assign uart_rx_err  = err_q;
    assign uart_rx_data = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised frame stimulus for uart_rx, checked against a
// byte-level model of what an 8N1 receiver should report.
module tb_uart_rx;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int      CLK_FREQ = 1600000;
    localparam int      UART_BPS = 100000;
    localparam int      BIT_CYC  = CLK_FREQ / UART_BPS;
    localparam realtime CLK_NS   = 10.0;
    localparam realtime BIT_NS   = CLK_NS * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       done;
    logic       err;
    logic       busy;
    logic [7:0] data;

    int checks = 0;
    int errors = 0;

    // Observed activity, gathered at the falling clock edge.
    logic [7:0] got_q[$];
    int         err_seen  = 0;
    int         both_seen = 0;
    int         run_len   = 0;
    int         last_run  = 0;

    // Reference model: bytes that should arrive and the byte that should be held.
    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         exp_err  = 0;

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rxd     (rxd),
        .uart_rx_done (done),
        .uart_rx_data (data),
        .uart_rx_err  (err),
        .uart_rx_busy (busy)
    );

    always @(negedge clk) begin
        if (done) got_q.push_back(data);
        if (err) err_seen++;
        if (done && err) both_seen++;
        if (busy) begin
            run_len++;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input realtime bit_t, input realtime stop_t, input bit align);
        if (align) begin
            @(posedge clk);
            #1;
        end
        rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_t);
        end
        rxd = stop_v;
        #(stop_t);
        rxd = 1'b1;
    endtask

    task automatic expect_good(input logic [7:0] b);
        exp_q.push_back(b);
        exp_data = b;
    endtask

    task automatic check_state(input string tag);
        chk({tag, " done count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, " byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, " err count"}, 32'(err_seen), 32'(exp_err));
        chk({tag, " held data"}, 32'(data), 32'(exp_data));
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        chk({tag, " done+err overlap"}, 32'(both_seen), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] fifo_bytes[4];
        logic [7:0] frame_5a;

        fifo_bytes = '{8'h00, 8'h55, 8'hAA, 8'hFF};
        frame_5a   = 8'h5A;

        // Reset state.
        rst = 1'b1;
        settle(4);
        rst = 1'b0;
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset data", 32'(data), 32'h00);
        settle(5);

        // Single ideal frame; busy spans nine full bits plus the half stop bit.
        last_run = 0;
        send_frame(8'hA5, 1'b1, BIT_NS, BIT_NS, 1'b1);
        settle(4);
        expect_good(8'hA5);
        check_state("a5");
        chk("a5 busy length", 32'(last_run), 32'(9 * BIT_CYC + 9));

        // Short low glitch: busy pulses briefly, nothing reported.
        last_run = 0;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxd = 1'b1;
        settle(3 * BIT_CYC);
        chk("glitch busy pulse", 32'(last_run > 0 && last_run < BIT_CYC), 32'd1);
        check_state("glitch");

        // Framing error keeps the held byte, then a good frame follows.
        send_frame(8'h3C, 1'b0, BIT_NS, BIT_NS, 1'b1);
        settle(4);
        exp_err++;
        check_state("stop low");
        settle(2 * BIT_CYC);
        send_frame(8'h81, 1'b1, BIT_NS, BIT_NS, 1'b1);
        settle(4);
        expect_good(8'h81);
        check_state("after err");

        // Back-to-back: second start arrives at 15/16 of the first stop bit.
        send_frame(8'h00, 1'b1, BIT_NS, BIT_NS * 15.0 / 16.0, 1'b1);
        send_frame(8'hFF, 1'b1, BIT_NS, BIT_NS, 1'b0);
        settle(4);
        expect_good(8'h00);
        expect_good(8'hFF);
        check_state("back to back");

        // Reset during data bit 4 discards the frame and clears the outputs.
        @(posedge clk);
        #1 rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxd = frame_5a[i];
            #(BIT_NS);
        end
        rxd = frame_5a[4];
        #(BIT_NS / 2);
        @(posedge clk);
        #1 rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset err", 32'(err), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset data", 32'(data), 32'h00);
        exp_data = 8'h00;
        settle(2 * BIT_CYC);
        check_state("midreset quiet");
        send_frame(8'h12, 1'b1, BIT_NS, BIT_NS, 1'b1);
        settle(4);
        expect_good(8'h12);
        check_state("after reset");

        // Random bytes with random idle gaps.
        for (int n = 0; n < 8; n++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, BIT_NS, BIT_NS, 1'b1);
            expect_good(rb);
            settle(1 + int'($urandom_range(0, 30)));
        end
        settle(4);
        check_state("random");

        // Sender running 2% fast and 2% slow.
        foreach (fifo_bytes[i]) begin
            send_frame(fifo_bytes[i], 1'b1, BIT_NS * 1.02, BIT_NS * 1.02, 1'b1);
            expect_good(fifo_bytes[i]);
            settle(2);
        end
        settle(4);
        check_state("slow sender");
        foreach (fifo_bytes[i]) begin
            send_frame(fifo_bytes[i], 1'b1, BIT_NS * 0.98, BIT_NS * 0.98, 1'b1);
            expect_good(fifo_bytes[i]);
            settle(2);
        end
        settle(4);
        check_state("fast sender");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
